// File: rtl/call_stack.sv
// Return-address stack: LIFO of 2**DEPTH addresses, top of stack on registered q.
// Latency: request sampled on a clock edge, state and q valid from that edge.
// Backpressure: none, one operation per cycle; a push while full is dropped or overwrites the oldest entry.
module call_stack #(
  parameter int WIDTH     = 11,
  parameter int DEPTH     = 7,
  parameter int OVERWRITE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [DEPTH:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int              N       = 1 << DEPTH;
  localparam logic [DEPTH:0]  CAP     = (DEPTH+1)'(N);
  localparam logic [DEPTH:0]  CNT_ONE = (DEPTH+1)'(1);
  localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
  localparam logic [DEPTH-1:0] PTR_TWO = DEPTH'(2);

  // Storage is a circular buffer; wr_ptr is the next free slot, so the top
  // lives at wr_ptr-1 and the oldest entry at wr_ptr-count. When full,
  // wr_ptr equals the oldest slot, which is what overwrite mode reuses.
  logic [WIDTH-1:0] mem_q [N];

  logic [WIDTH-1:0] top_q,      top_d;
  logic [DEPTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [DEPTH:0]   count_q,    count_d;
  logic             ovf_q,      ovf_d;
  logic             unf_q,      unf_d;

  logic             mem_we;
  logic [DEPTH-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdat;

  logic [DEPTH-1:0] top_idx;
  logic [DEPTH-1:0] below_idx;
  logic [WIDTH-1:0] below_dat;
  logic             is_empty;
  logic             is_full;

  assign top_idx   = wr_ptr_q - PTR_ONE;
  assign below_idx = wr_ptr_q - PTR_TWO;
  // Combinational read so a pop can present the next entry on the same edge.
  assign below_dat = mem_q[below_idx];
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CAP);

  // Next-state: flush, then push+pop, then push, then pop, else hold.
  always_comb begin
    top_d     = top_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdat  = d;

    if (flush) begin
      top_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push && pop) begin
      if (is_empty) begin
        // Nothing to replace: flag the pop, then act as a plain push.
        unf_d    = 1'b1;
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = CNT_ONE;
        top_d    = d;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = top_idx;
        top_d     = d;
      end
    end else if (push) begin
      if (!is_full) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + CNT_ONE;
        top_d    = d;
      end else begin
        ovf_d = 1'b1;
        if (OVERWRITE != 0) begin
          // Free slot is the oldest entry; advancing wr_ptr retires it.
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          top_d    = d;
        end
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q - PTR_ONE;
        count_d  = count_q - CNT_ONE;
        top_d    = (count_q == CNT_ONE) ? '0 : below_dat;
      end
    end
  end

  // Control and top-of-stack registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q    <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      top_q    <= top_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entry storage; contents are meaningless outside the valid window.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  assign q         = top_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: two instances (reject-when-full and overwrite-oldest) share stimulus.
// Expected state is produced by a queue-based model and queued per edge; a monitor compares.
// Directed scenarios first, then randomized operations with occasional asynchronous resets.
module tb_call_stack;

  localparam int W   = 11;
  localparam int D   = 2;
  localparam int CAP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         push, pop, flush;
  logic [W-1:0] d;

  logic [W-1:0] q0, q1;
  logic [D:0]   cnt0, cnt1;
  logic         emp0, emp1, ful0, ful1, ovf0, ovf1, unf0, unf1;

  call_stack #(.WIDTH(W), .DEPTH(D), .OVERWRITE(0)) u_rej (
    .clk(clk), .reset(rst_n), .push(push), .pop(pop), .flush(flush), .d(d),
    .q(q0), .count(cnt0), .empty(emp0), .full(ful0),
    .overflow(ovf0), .underflow(unf0)
  );

  call_stack #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1)) u_ovw (
    .clk(clk), .reset(rst_n), .push(push), .pop(pop), .flush(flush), .d(d),
    .q(q1), .count(cnt1), .empty(emp1), .full(ful1),
    .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    int q;
    int cnt;
    bit emp;
    bit ful;
    bit ovf;
    bit unf;
  } st_t;

  st_t   eq0[$];
  st_t   eq1[$];
  string tag_q[$];

  // Reference model: a plain queue per mode, oldest at the front.
  int s0[$];
  int s1[$];
  bit m_ovf[2];
  bit m_unf[2];

  int    checks = 0;
  int    errors = 0;
  bit    running = 1'b0;
  string cur_tag = "reset";
  event  chk_ev;

  function automatic st_t snap(input int s[$], input bit ov, input bit un);
    st_t e;
    e.q   = (s.size() > 0) ? s[s.size()-1] : 0;
    e.cnt = s.size();
    e.emp = (s.size() == 0);
    e.ful = (s.size() == CAP);
    e.ovf = ov;
    e.unf = un;
    return e;
  endfunction

  task automatic model_reset();
    s0.delete();
    s1.delete();
    m_ovf[0] = 0; m_ovf[1] = 0;
    m_unf[0] = 0; m_unf[1] = 0;
  endtask

  task automatic model_apply(input bit p, input bit po, input bit f, input int dv);
    for (int m = 0; m < 2; m++) begin
      int s[$];
      bit ov;
      bit un;
      if (m == 0) s = s0; else s = s1;
      ov = m_ovf[m];
      un = m_unf[m];
      if (f) begin
        s.delete();
        ov = 0;
        un = 0;
      end else if (p && po) begin
        if (s.size() == 0) begin
          un = 1;
          s.push_back(dv);
        end else begin
          s[s.size()-1] = dv;
        end
      end else if (p) begin
        if (s.size() < CAP) begin
          s.push_back(dv);
        end else begin
          ov = 1;
          if (m == 1) begin
            void'(s.pop_front());
            s.push_back(dv);
          end
        end
      end else if (po) begin
        if (s.size() == 0) un = 1;
        else void'(s.pop_back());
      end
      if (m == 0) s0 = s; else s1 = s;
      m_ovf[m] = ov;
      m_unf[m] = un;
    end
  endtask

  task automatic push_exp();
    eq0.push_back(snap(s0, m_ovf[0], m_unf[0]));
    eq1.push_back(snap(s1, m_ovf[1], m_unf[1]));
    tag_q.push_back(cur_tag);
    running = 1'b1;
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge.
  task automatic cycle(input bit p, input bit po, input bit f, input int dv);
    @(negedge clk);
    push  = p;
    pop   = po;
    flush = f;
    d     = W'(dv);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_apply(p, po, f, dv);
    push_exp();
  endtask

  task automatic op_push(input int dv);     cycle(1, 0, 0, dv); endtask
  task automatic op_pop();                  cycle(0, 1, 0, 0);  endtask
  task automatic op_pp(input int dv);       cycle(1, 1, 0, dv); endtask
  task automatic op_flush();                cycle(0, 0, 1, 0);  endtask

  // Assert reset between edges, check immediately, hold across one edge, release.
  task automatic mid_reset();
    @(negedge clk);
    push = 0; pop = 0; flush = 0;
    #2;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    -> chk_ev;
    @(posedge clk);
    model_reset();
    push_exp();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic cmp(input string tag, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h at %0t", tag, fld, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT state is observable, pop one expectation and compare.
  initial begin
    st_t   e0;
    st_t   e1;
    string t;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (eq0.size() == 0 || eq1.size() == 0) begin
        if (running) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end
      end else begin
        e0 = eq0.pop_front();
        e1 = eq1.pop_front();
        t  = tag_q.pop_front();
        cmp({t, "/rej"}, "q",         int'(q0),   e0.q);
        cmp({t, "/rej"}, "count",     int'(cnt0), e0.cnt);
        cmp({t, "/rej"}, "empty",     int'(emp0), int'(e0.emp));
        cmp({t, "/rej"}, "full",      int'(ful0), int'(e0.ful));
        cmp({t, "/rej"}, "overflow",  int'(ovf0), int'(e0.ovf));
        cmp({t, "/rej"}, "underflow", int'(unf0), int'(e0.unf));
        cmp({t, "/ovw"}, "q",         int'(q1),   e1.q);
        cmp({t, "/ovw"}, "count",     int'(cnt1), e1.cnt);
        cmp({t, "/ovw"}, "empty",     int'(emp1), int'(e1.emp));
        cmp({t, "/ovw"}, "full",      int'(ful1), int'(e1.ful));
        cmp({t, "/ovw"}, "overflow",  int'(ovf1), int'(e1.ovf));
        cmp({t, "/ovw"}, "underflow", int'(unf1), int'(e1.unf));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rst_n = 1'b0;
    push = 0; pop = 0; flush = 0; d = '0;
    model_reset();

    cur_tag = "reset";
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2 rst_n = 1'b1;

    cur_tag = "lifo";
    op_push(11'h001); op_push(11'h002); op_push(11'h003);
    op_pop();

    cur_tag = "fill";
    op_flush();
    for (int i = 1; i <= 5; i++) op_push(i);
    for (int i = 0; i < 4; i++) op_pop();
    op_pop();

    cur_tag = "pp_empty";
    op_flush();
    op_pp(11'h1AB);
    cur_tag = "pp_replace";
    op_flush();
    op_push(11'h050); op_push(11'h0A0);
    op_pp(11'h123);
    op_pop();

    cur_tag = "pp_full";
    op_flush();
    for (int i = 0; i < 4; i++) op_push(11'h100 + i);
    op_pp(11'h7FF);
    cur_tag = "flush_push";
    cycle(1, 0, 1, 11'h3C3);

    cur_tag = "async_reset";
    op_pop();
    for (int i = 0; i < 5; i++) op_push(11'h020 + i);
    op_pop(); op_pop();
    mid_reset();
    op_push(11'h010);

    cur_tag = "random";
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        mid_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 2)       op_flush();
        else if (r < 42) op_push(int'($urandom_range(0, 2047)));
        else if (r < 76) op_pop();
        else if (r < 88) op_pp(int'($urandom_range(0, 2047)));
        else             cycle(0, 0, 0, int'($urandom_range(0, 2047)));
      end
    end

    @(negedge clk);
    push = 0; pop = 0; flush = 0;
    running = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (eq0.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left expected 0", eq0.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
